// File: rtl/rr_grant_sched8.sv
// 8-way round-robin grant scheduler with a registered one-hot grant and encoded index.
// Optional hold-limit revocation is enabled by defining ARB_TIMEOUT_EN.
module rr_grant_sched8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = $clog2(MAX_HOLD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] grant_s;
  logic [2:0] idx_s;
  logic       valid_s;
  logic       timeout_s;
  logic       hold_expire_s;
  logic [3:0] pick_s;
  logic [3:0] pick_masked_s;

  // Returns {found, index} of the first set bit after ptr, wrapping; ptr itself is checked last.
  function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] c;
    res = 4'b0000;
    for (int k = 8; k >= 1; k--) begin
      c = ptr + 3'(k);
      if (r[c]) begin
        res = {1'b1, c};
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] i);
    return 8'd1 << i;
  endfunction

  assign pick_s        = rr_search(req, grant_idx);
  assign pick_masked_s = rr_search(req & ~grant, grant_idx);

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_s;

  assign hold_expire_s = (hold_r == HOLD_W'(MAX_HOLD - 1));

  // Hold counter restarts on every fresh grant (including a timeout re-grant).
  always_comb begin
    hold_s = hold_r;
    if ((state_s != GRANT) || (state_r != GRANT) || timeout_s || (idx_s != grant_idx)) begin
      hold_s = {HOLD_W{1'b0}};
    end else begin
      hold_s = hold_r + HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= {HOLD_W{1'b0}};
    end else begin
      hold_r <= hold_s;
    end
  end
`else
  assign hold_expire_s = 1'b0;
`endif

  // Next-state and next-output selection.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant;
    idx_s     = grant_idx;
    valid_s   = grant_valid;
    timeout_s = 1'b0;
    if (!en) begin
      state_s = IDLE;
      grant_s = 8'h00;
      valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_s[3]) begin
            state_s = GRANT;
            grant_s = onehot8(pick_s[2:0]);
            idx_s   = pick_s[2:0];
            valid_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        GRANT: begin
          if (req[grant_idx]) begin
            if (hold_expire_s) begin
              timeout_s = 1'b1;
              // With nobody else pending the holder simply keeps the grant.
              if (pick_masked_s[3]) begin
                grant_s = onehot8(pick_masked_s[2:0]);
                idx_s   = pick_masked_s[2:0];
              end else begin
                grant_s = grant;
              end
            end else begin
              state_s = GRANT;
            end
          end else if (pick_s[3]) begin
            grant_s = onehot8(pick_s[2:0]);
            idx_s   = pick_s[2:0];
          end else begin
            state_s = IDLE;
            grant_s = 8'h00;
            valid_s = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
          grant_s = 8'h00;
          valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; grant_idx resets to 7 so the first search starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      grant       <= 8'h00;
      grant_idx   <= 3'd7;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_r     <= state_s;
      grant       <= grant_s;
      grant_idx   <= idx_s;
      grant_valid <= valid_s;
      timeout     <= timeout_s;
    end
  end

endmodule

// File: tb/tb_rr_grant_sched8.sv
// Self-checking bench for rr_grant_sched8: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_rr_grant_sched8;

  localparam int TB_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int total  = 0;
  int passed = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_hold;
  bit m_timeout;

  always #5 clk = ~clk;

  rr_grant_sched8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  function automatic int rr_pick(logic [7:0] r, int ptr);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (ptr + k) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [12:0] dut_vec();
    return {grant, grant_idx, grant_valid, timeout};
  endfunction

  function automatic logic [12:0] m_vec();
    logic [7:0] g;
    g = m_valid ? 8'(1 << m_idx) : 8'h00;
    return {g, 3'(m_idx), m_valid, m_timeout};
  endfunction

  function automatic logic [12:0] mk(int idx, bit v, bit t);
    logic [7:0] g;
    g = v ? 8'(1 << idx) : 8'h00;
    return {g, 3'(idx), v, t};
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_idx     = 7;
    m_hold    = 0;
    m_timeout = 1'b0;
  endtask

  task automatic model_step();
    int w;
    m_timeout = 1'b0;
    if (!en) begin
      m_valid = 1'b0;
    end else if (!m_valid) begin
      w = rr_pick(req, m_idx);
      if (w >= 0) begin m_valid = 1'b1; m_idx = w; m_hold = 0; end
    end else if (req[m_idx]) begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == TB_MAX_HOLD - 1) begin
        logic [7:0] masked;
        masked = req;
        masked[m_idx] = 1'b0;
        w = rr_pick(masked, m_idx);
        if (w >= 0) m_idx = w;
        m_hold = 0;
        m_timeout = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end else begin
      w = rr_pick(req, m_idx);
      if (w >= 0) begin m_idx = w; m_hold = 0; end
      else m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = 8'h00;
    en  = 1'b0;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (dut_vec() !== mk(7, 1'b0, 1'b0)) $display("FAIL reset_state got %h exp %h", dut_vec(), mk(7, 1'b0, 1'b0));
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    total++;
    if (dut_vec() !== mk(7, 1'b0, 1'b0)) $display("FAIL reset_idle got %h exp %h", dut_vec(), mk(7, 1'b0, 1'b0));
    else passed++;
  endtask

  task automatic test_mid_reset();
    en = 1'b1; req = 8'h08;
    tick();
    total++;
    if (dut_vec() !== mk(3, 1'b1, 1'b0)) $display("FAIL mid_reset_pre got %h exp %h", dut_vec(), mk(3, 1'b1, 1'b0));
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (dut_vec() !== mk(7, 1'b0, 1'b0)) $display("FAIL mid_reset_async got %h exp %h", dut_vec(), mk(7, 1'b0, 1'b0));
    else passed++;
    req = 8'h00;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    en = 1'b1; req = 8'h08;
    tick();
    total++;
    if (dut_vec() !== mk(3, 1'b1, 1'b0)) $display("FAIL single_grant got %h exp %h", dut_vec(), mk(3, 1'b1, 1'b0));
    else passed++;
    req = 8'h00;
    tick();
    total++;
    if (dut_vec() !== mk(3, 1'b0, 1'b0)) $display("FAIL single_release got %h exp %h", dut_vec(), mk(3, 1'b0, 1'b0));
    else passed++;
  endtask

  task automatic test_rotation();
    apply_reset();
    en = 1'b1; req = 8'hFF;
    tick();
    for (int i = 0; i <= 8; i++) begin
      int e;
      logic [7:0] r;
      e = i % 8;
      total++;
      if (dut_vec() !== mk(e, 1'b1, 1'b0)) $display("FAIL rotation_first i=%0d got %h exp %h", i, dut_vec(), mk(e, 1'b1, 1'b0));
      else passed++;
      tick();
      total++;
      if (dut_vec() !== mk(e, 1'b1, 1'b0)) $display("FAIL rotation_hold i=%0d got %h exp %h", i, dut_vec(), mk(e, 1'b1, 1'b0));
      else passed++;
      if (i < 8) begin
        r = 8'hFF;
        r[e] = 1'b0;
        req = r;
        tick();
        req = 8'hFF;
      end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    en = 1'b1; req = 8'h20;
    tick();
    total++;
    if (dut_vec() !== mk(5, 1'b1, 1'b0)) $display("FAIL enable_grant5 got %h exp %h", dut_vec(), mk(5, 1'b1, 1'b0));
    else passed++;
    en = 1'b0;
    tick();
    total++;
    if (dut_vec() !== mk(5, 1'b0, 1'b0)) $display("FAIL enable_off got %h exp %h", dut_vec(), mk(5, 1'b0, 1'b0));
    else passed++;
    en = 1'b1; req = 8'hFF;
    tick();
    total++;
    if (dut_vec() !== mk(6, 1'b1, 1'b0)) $display("FAIL enable_resume got %h exp %h", dut_vec(), mk(6, 1'b1, 1'b0));
    else passed++;
  endtask

  task automatic test_wrap_release();
    req = 8'h40;
    tick();
    total++;
    if (dut_vec() !== mk(6, 1'b1, 1'b0)) $display("FAIL wrap_holder6 got %h exp %h", dut_vec(), mk(6, 1'b1, 1'b0));
    else passed++;
    req = 8'h01;
    tick();
    total++;
    if (dut_vec() !== mk(0, 1'b1, 1'b0)) $display("FAIL wrap_to0 got %h exp %h", dut_vec(), mk(0, 1'b1, 1'b0));
    else passed++;
  endtask

  task automatic test_timeout();
    apply_reset();
    en = 1'b1; req = 8'h24;
    tick();
    for (int c = 0; c < 12; c++) begin
      int e;
      bit t;
`ifdef ARB_TIMEOUT_EN
      e = (((c / TB_MAX_HOLD) % 2) == 0) ? 2 : 5;
      t = ((c % TB_MAX_HOLD) == 0) && (c > 0);
`else
      e = 2;
      t = 1'b0;
`endif
      total++;
      if (dut_vec() !== mk(e, 1'b1, t)) $display("FAIL timeout_seq c=%0d got %h exp %h", c, dut_vec(), mk(e, 1'b1, t));
      else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      en = ($urandom_range(0, 15) != 0);
      r = 8'($urandom) & 8'($urandom);
      if (m_valid && ($urandom_range(0, 3) != 0)) r[m_idx] = 1'b1;
      req = r;
      tick();
      total++;
      if (dut_vec() !== m_vec()) $display("FAIL random n=%0d req=%h got %h exp %h", n, r, dut_vec(), m_vec());
      else passed++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", total);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = 8'h00;
    model_reset();
    test_reset();
    test_mid_reset();
    test_single();
    test_rotation();
    test_enable();
    test_wrap_release();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
